// File: rtl/npc_ctrl_fsm.sv
// npc_ctrl_fsm: multi-cycle control sequencer for the single-issue NPC core.
// Steps each instruction through FETCH -> EXEC -> [MEM] -> WB and qualifies
// the EXU's PC/GPR write requests so that architectural state changes exactly
// once per retired instruction. Handles ebreak halt, invalid instruction types
// and fetch/memory wait timeouts, and counts retired instructions.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ifu_req           fetch request (FETCH state)
//   ifu_valid         instruction word available
//   inst_latch_en     instruction register load pulse (FETCH & ifu_valid)
//   inst_type         decoded type, R=0 I=1 S=2 B=3 U=4 J=5, others invalid
//   is_load/is_store/is_ebreak  decode flags, valid in EXEC
//   pc_w_req/gpr_w_req          EXU write requests
//   lsu_req, lsu_we   memory request (MEM state) and store indication
//   lsu_valid         memory access complete
//   pc_w_en/gpr_w_en  qualified write enables, only ever high in WB
//   halt, error       sticky terminal status
//   retire_cnt        retired-instruction counter (wraps)
//   state             current state encoding, for debug

module npc_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter int unsigned INST_TYPE_WIDTH = 3,
  parameter int unsigned ISA_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ifu_req,
  input  logic                       ifu_valid,
  output logic                       inst_latch_en,
  input  logic [INST_TYPE_WIDTH-1:0] inst_type,
  input  logic                       is_load,
  input  logic                       is_store,
  input  logic                       is_ebreak,
  input  logic                       pc_w_req,
  input  logic                       gpr_w_req,
  output logic                       lsu_req,
  output logic                       lsu_we,
  input  logic                       lsu_valid,
  output logic                       pc_w_en,
  output logic                       gpr_w_en,
  output logic                       halt,
  output logic                       error,
  output logic [ISA_WIDTH-1:0]       retire_cnt,
  output logic [2:0]                 state
);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  // A zero timeout disables the check; the counter is kept 1 bit wide then.
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned WAIT_W     = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  // Types R..J occupy codes 0..5.
  localparam logic [INST_TYPE_WIDTH-1:0] TYPE_LIMIT = INST_TYPE_WIDTH'(6);

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    wait_q, wait_d;
  logic [ISA_WIDTH-1:0] retire_q, retire_d;
  logic                 type_ok;
  logic                 wait_expired;

  assign type_ok      = (inst_type < TYPE_LIMIT);
  assign wait_expired = TIMEOUT_EN && (wait_q == WAIT_LAST);

  // State, wait counter and retire counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      wait_q   <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      retire_q <= retire_d;
    end
  end

  // Next-state logic and output decode.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    retire_d      = retire_q;
    ifu_req       = 1'b0;
    inst_latch_en = 1'b0;
    lsu_req       = 1'b0;
    lsu_we        = 1'b0;
    pc_w_en       = 1'b0;
    gpr_w_en      = 1'b0;
    halt          = 1'b0;
    error         = 1'b0;

    case (state_q)
      ST_FETCH: begin
        ifu_req = 1'b1;
        // A valid in the final wait cycle beats the timeout.
        if (ifu_valid) begin
          inst_latch_en = 1'b1;
          state_d       = ST_EXEC;
        end else if (wait_expired) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_EXEC: begin
        if (!type_ok) begin
          state_d = ST_ERROR;
        end else if (is_ebreak) begin
          state_d  = ST_HALT;
          retire_d = retire_q + ISA_WIDTH'(1);
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
          wait_d  = '0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        lsu_req = 1'b1;
        lsu_we  = is_store;
        if (lsu_valid) begin
          state_d = ST_WB;
        end else if (wait_expired) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WB: begin
        pc_w_en  = pc_w_req;
        gpr_w_en = gpr_w_req & ~is_store;
        retire_d = retire_q + ISA_WIDTH'(1);
        state_d  = ST_FETCH;
        wait_d   = '0;
      end
      ST_HALT: begin
        halt = 1'b1;
      end
      ST_ERROR: begin
        error = 1'b1;
      end
      default: begin
        // Unreachable encodings fall into ERROR.
        state_d = ST_ERROR;
      end
    endcase
  end

  assign retire_cnt = retire_q;
  assign state      = state_q;

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
module tb_npc_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic        ifu_valid, lsu_valid;
  logic [2:0]  inst_type;
  logic        is_load, is_store, is_ebreak, pc_w_req, gpr_w_req;

  logic        ifu_req, inst_latch_en, lsu_req, lsu_we, pc_w_en, gpr_w_en, halt, error;
  logic [31:0] retire_cnt;
  logic [2:0]  state;

  logic        d2_ifu_req, d2_inst_latch_en, d2_lsu_req, d2_lsu_we, d2_pc_w_en, d2_gpr_w_en;
  logic        d2_halt, d2_error;
  logic [31:0] d2_retire_cnt;
  logic [2:0]  d2_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] sb[$];

  npc_ctrl_fsm #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_valid(ifu_valid),
    .inst_latch_en(inst_latch_en), .inst_type(inst_type), .is_load(is_load),
    .is_store(is_store), .is_ebreak(is_ebreak), .pc_w_req(pc_w_req),
    .gpr_w_req(gpr_w_req), .lsu_req(lsu_req), .lsu_we(lsu_we),
    .lsu_valid(lsu_valid), .pc_w_en(pc_w_en), .gpr_w_en(gpr_w_en),
    .halt(halt), .error(error), .retire_cnt(retire_cnt), .state(state)
  );

  npc_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk(clk), .rst(rst), .ifu_req(d2_ifu_req), .ifu_valid(ifu_valid),
    .inst_latch_en(d2_inst_latch_en), .inst_type(inst_type), .is_load(is_load),
    .is_store(is_store), .is_ebreak(is_ebreak), .pc_w_req(pc_w_req),
    .gpr_w_req(gpr_w_req), .lsu_req(d2_lsu_req), .lsu_we(d2_lsu_we),
    .lsu_valid(lsu_valid), .pc_w_en(d2_pc_w_en), .gpr_w_en(d2_gpr_w_en),
    .halt(d2_halt), .error(d2_error), .retire_cnt(d2_retire_cnt), .state(d2_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector: {state, ifu_req, latch, lsu_req, lsu_we, pc_en, gpr_en, halt, error}
  function automatic logic [10:0] obs1();
    return {state, ifu_req, inst_latch_en, lsu_req, lsu_we, pc_w_en, gpr_w_en, halt, error};
  endfunction

  function automatic logic [10:0] obs2();
    return {d2_state, d2_ifu_req, d2_inst_latch_en, d2_lsu_req, d2_lsu_we,
            d2_pc_w_en, d2_gpr_w_en, d2_halt, d2_error};
  endfunction

  // Expected vector: Moore outputs follow from the state code.
  function automatic logic [10:0] mk(input logic [2:0] st, input logic latch,
                                     input logic we, input logic pc, input logic gpr);
    return {st, st == 3'd0, latch, st == 3'd2, we, pc, gpr, st == 3'd4, st == 3'd5};
  endfunction

  task automatic clear_inputs();
    ifu_valid = 0; lsu_valid = 0; inst_type = 3'd1;
    is_load = 0; is_store = 0; is_ebreak = 0; pc_w_req = 0; gpr_w_req = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    do_reset();
    sb.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++;
    if (obs1() !== e) begin n_bad++; $display("FAIL reset_outputs: got %b want %b", obs1(), e); end
    n_cmp++;
    if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_retire: got %0d want 0", retire_cnt); end
    n_cmp++;
    if (obs2() !== e) begin n_bad++; $display("FAIL reset_outputs_to: got %b want %b", obs2(), e); end
  endtask

  task automatic test_alu();
    logic [10:0] e;
    int pc_n = 0, gpr_n = 0;
    do_reset();
    inst_type = 3'd1; pc_w_req = 1; gpr_w_req = 1; ifu_valid = 1;
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0:       sb.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        1:       sb.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        default: sb.push_back(mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b1));
      endcase
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs1() !== e) begin n_bad++; $display("FAIL alu cyc%0d: got %b want %b", i, obs1(), e); end
      if (pc_w_en) pc_n++;
      if (gpr_w_en) gpr_n++;
      @(posedge clk); #1;
      if (i == 2) begin
        n_cmp++;
        if (retire_cnt !== 32'd1) begin n_bad++; $display("FAIL alu_retire1: got %0d want 1", retire_cnt); end
      end
    end
    n_cmp++;
    if (retire_cnt !== 32'd10) begin n_bad++; $display("FAIL alu_retire10: got %0d want 10", retire_cnt); end
    n_cmp++;
    if (pc_n != 10 || gpr_n != 10) begin
      n_bad++; $display("FAIL alu_pulses: got pc=%0d gpr=%0d want 10/10", pc_n, gpr_n);
    end
  endtask

  task automatic test_store();
    logic [10:0] e;
    int req_n = 0;
    do_reset();
    inst_type = 3'd2; is_store = 1; pc_w_req = 1; gpr_w_req = 1; ifu_valid = 1;
    for (int i = 0; i < 10; i++) begin
      lsu_valid = (i == 7);
      if (i == 0 || i == 9) sb.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      else if (i == 1)      sb.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
      else if (i <= 7)      sb.push_back(mk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0));
      else                  sb.push_back(mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs1() !== e) begin n_bad++; $display("FAIL store cyc%0d: got %b want %b", i, obs1(), e); end
      if (lsu_req) req_n++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (req_n != 6) begin n_bad++; $display("FAIL store_lsu_req_len: got %0d want 6", req_n); end
    n_cmp++;
    if (retire_cnt !== 32'd1) begin n_bad++; $display("FAIL store_retire: got %0d want 1", retire_cnt); end
  endtask

  task automatic test_ebreak();
    logic [10:0] e;
    int en_n = 0;
    do_reset();
    inst_type = 3'd1; is_ebreak = 1; pc_w_req = 1; gpr_w_req = 1; ifu_valid = 1; lsu_valid = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      sb.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      else if (i == 1) sb.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
      else             sb.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs1() !== e) begin n_bad++; $display("FAIL ebreak cyc%0d: got %b want %b", i, obs1(), e); end
      if (pc_w_en || gpr_w_en) en_n++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (retire_cnt !== 32'd1 || en_n != 0) begin
      n_bad++; $display("FAIL ebreak_retire: got retire=%0d en=%0d want 1/0", retire_cnt, en_n);
    end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (state !== 3'd0 || retire_cnt !== 32'd0 || halt !== 1'b0) begin
      n_bad++; $display("FAIL ebreak_rst: got st=%0d retire=%0d halt=%b want 0/0/0", state, retire_cnt, halt);
    end
  endtask

  task automatic test_invalid();
    logic [10:0] e;
    do_reset();
    inst_type = 3'd7; pc_w_req = 1; gpr_w_req = 1; ifu_valid = 1;
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      sb.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      else if (i == 1) sb.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
      else             sb.push_back(mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs1() !== e) begin n_bad++; $display("FAIL invalid cyc%0d: got %b want %b", i, obs1(), e); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (retire_cnt !== 32'd0) begin n_bad++; $display("FAIL invalid_retire: got %0d want 0", retire_cnt); end
  endtask

  task automatic test_timeout();
    logic [10:0] e;
    // Fetch timeout: exactly 4 FETCH cycles without ifu_valid.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sb.push_back(mk((i < 4) ? 3'd0 : 3'd5, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs2() !== e) begin n_bad++; $display("FAIL fetch_timeout cyc%0d: got %b want %b", i, obs2(), e); end
      @(posedge clk); #1;
    end
    // Valid in the 4th cycle wins; then a load waits 4 MEM cycles and times out.
    do_reset();
    inst_type = 3'd1; is_load = 1;
    for (int i = 0; i < 11; i++) begin
      ifu_valid = (i == 3);
      if (i < 4)       sb.push_back(mk(3'd0, i == 3, 1'b0, 1'b0, 1'b0));
      else if (i == 4) sb.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
      else if (i < 9)  sb.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
      else             sb.push_back(mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs2() !== e) begin n_bad++; $display("FAIL late_valid cyc%0d: got %b want %b", i, obs2(), e); end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (d2_retire_cnt !== 32'd0) begin n_bad++; $display("FAIL timeout_retire: got %0d want 0", d2_retire_cnt); end
  endtask

  task automatic test_reset_mid_mem();
    logic [10:0] e;
    int gpr_n = 0;
    do_reset();
    inst_type = 3'd1; is_load = 1; pc_w_req = 1; gpr_w_req = 1;
    for (int i = 0; i < 6; i++) begin
      rst       = (i == 3);
      lsu_valid = (i == 3);
      ifu_valid = (i < 3);
      if (i == 0)      sb.push_back(mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      else if (i == 1) sb.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0));
      else if (i < 4)  sb.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
      else             sb.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs1() !== e) begin n_bad++; $display("FAIL rst_mem cyc%0d: got %b want %b", i, obs1(), e); end
      if (gpr_w_en) gpr_n++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    n_cmp++;
    if (retire_cnt !== 32'd0 || gpr_n != 0) begin
      n_bad++; $display("FAIL rst_mem_retire: got retire=%0d gpr=%0d want 0/0", retire_cnt, gpr_n);
    end
  endtask

  task automatic test_random();
    logic [10:0] e;
    logic [2:0]  st = 3'd0;
    int ret = 0, ebreaks = 0, pc_n = 0, r;
    do_reset();
    pc_w_req = 1;
    for (int i = 0; i < 400; i++) begin
      ifu_valid = 1'($urandom_range(0, 1));
      lsu_valid = 1'($urandom_range(0, 1));
      inst_type = 3'($urandom_range(0, 5));
      r = int'($urandom_range(0, 2));
      is_load   = (r == 1);
      is_store  = (r == 2);
      gpr_w_req = 1'($urandom_range(0, 1));
      is_ebreak = (i > 300) && (st == 3'd1) && (ebreaks == 0);
      sb.push_back(mk(st, (st == 3'd0) && ifu_valid, (st == 3'd2) && is_store,
                      st == 3'd3, (st == 3'd3) && gpr_w_req && !is_store));
      @(negedge clk);
      e = sb.pop_front();
      n_cmp++;
      if (obs1() !== e) begin n_bad++; $display("FAIL random cyc%0d: got %b want %b", i, obs1(), e); end
      if (pc_w_en) pc_n++;
      case (st)
        3'd0: if (ifu_valid) st = 3'd1;
        3'd1: begin
          if (is_ebreak) begin st = 3'd4; ret++; ebreaks++; end
          else if (is_load || is_store) st = 3'd2;
          else st = 3'd3;
        end
        3'd2: if (lsu_valid) st = 3'd3;
        3'd3: begin ret++; st = 3'd0; end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    n_cmp++;
    if (retire_cnt !== 32'(ret)) begin n_bad++; $display("FAIL random_retire: got %0d want %0d", retire_cnt, ret); end
    n_cmp++;
    if (pc_n != ret - ebreaks) begin
      n_bad++; $display("FAIL random_pc_pulses: got %0d want %0d", pc_n, ret - ebreaks);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_alu();
    test_store();
    test_ebreak();
    test_invalid();
    test_timeout();
    test_reset_mid_mem();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/npc_ctrl_fsm.md
# npc_ctrl_fsm

Multi-cycle control sequencer for the single-issue NPC core. It steps each instruction through fetch, execute, optional memory access and writeback, and is the only block allowed to assert the architectural write enables. The EXU's PC and GPR write requests are qualified here, so the PC and register file change exactly once per retired instruction. It also handles `ebreak` halt, unknown instruction types and memory-wait timeouts, and keeps a retired-instruction counter.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum wait for `ifu_valid` or `lsu_valid`. A value of 0 disables the timeout.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  core clock; all state updates on the rising edge.
  - `rst`  in  1  synchronous, active-high reset.
- Instruction fetch:
  - `ifu_req`  out  1  fetch request; held high for the whole FETCH state.
  - `ifu_valid`  in  1  instruction word available this cycle.
  - `inst_latch_en`  out  1  one-cycle pulse that loads the instruction register.
- Decode and execute status:
  - `inst_type`  in  `INST_TYPE_WIDTH`  decoded type (R/I/S/B/U/J; any other value is invalid).
  - `is_load`, `is_store`, `is_ebreak`  in  1 each  decode flags.
  - `pc_w_req`  in  1  EXU PC-write request.
  - `gpr_w_req`  in  1  EXU register-write request.
- Memory access:
  - `lsu_req`  out  1  memory access request; held high for the whole MEM state.
  - `lsu_we`  out  1  store indication; equals `is_store` while in MEM, 0 otherwise.
  - `lsu_valid`  in  1  memory access complete.
- Qualified write enables:
  - `pc_w_en`  out  1  qualified PC write.
  - `gpr_w_en`  out  1  qualified GPR write.
- Status and debug:
  - `halt`  out  1  `ebreak` reached; sticky until reset.
  - `error`  out  1  invalid type or timeout; sticky until reset.
  - `retire_cnt`  out  `ISA_WIDTH`  number of retired instructions.
  - `state`  out  3  current state encoding, for debug.

## Operation

- State encodings: FETCH=0, EXEC=1, MEM=2, WB=3, HALT=4, ERROR=5. Codes 6 and 7 are unreachable and transition to ERROR.
- FETCH:
  - `ifu_req`=1.
  - On `ifu_valid`: pulse `inst_latch_en` in the same cycle, then go to EXEC.
- EXEC (decode inputs are valid in this state):
  - Priority 1: `inst_type` not in {R,I,S,B,U,J} → ERROR.
  - Priority 2: `is_ebreak` → HALT. `retire_cnt` increments; `pc_w_en` and `gpr_w_en` are not asserted.
  - Priority 3: `is_load` or `is_store` → MEM.
  - Otherwise → WB.
- MEM:
  - `lsu_req`=1 and `lsu_we`=`is_store`.
  - On `lsu_valid` → WB.
- WB:
  - `pc_w_en`=`pc_w_req`.
  - `gpr_w_en`=`gpr_w_req & ~is_store`.
  - `retire_cnt`+1, then go to FETCH.
- HALT and ERROR are terminal; only `rst` leaves them. In both states all request and enable outputs are 0.
- Write enables are never asserted outside WB. This holds even if the EXU raises `pc_w_req` or `gpr_w_req` in other states.
- Wait counter:
  - Width is `$clog2(TIMEOUT_CYCLES+1)`.
  - Cleared on entry to FETCH and on entry to MEM.
  - Increments each cycle in FETCH or MEM while the matching valid is low.
  - When the counter equals `TIMEOUT_CYCLES-1` and valid is still low → ERROR. This is exactly `TIMEOUT_CYCLES` cycles without valid.
  - A valid that arrives in that final cycle wins over the timeout.
- `retire_cnt` wraps modulo 2^`ISA_WIDTH` with no flag.
- Inputs are ignored in states where they have no meaning: a stray `ifu_valid` outside FETCH or a stray `lsu_valid` outside MEM has no effect.

## Timing

- Reset values (the cycle after `rst` is sampled high): `state`=FETCH, `retire_cnt`=0, wait counter=0, `halt`=0, `error`=0.
- Reset has priority over every transition, including a reset asserted mid-MEM or in HALT/ERROR.
- All outputs are Moore-style decodes of `state`, except the following, which are combinational in the current cycle:
  - `inst_latch_en` (`state`=FETCH & `ifu_valid`);
  - `lsu_we`, `pc_w_en`, `gpr_w_en`.
- Latency with zero-wait memories:
  - ALU, branch or jump instruction: 3 cycles (FETCH, EXEC, WB).
  - Load or store: 4 cycles (FETCH, EXEC, MEM, WB).
  - Each memory wait cycle adds 1.
- `ifu_req` rises in the first cycle after reset and in the cycle after WB.

## Test plan

- Reset, then `ifu_valid`=1 held continuously with an `addi` (type I, `pc_w_req`=`gpr_w_req`=1): `state` sequence 0,1,3,0; `pc_w_en` and `gpr_w_en` each high for exactly 1 cycle; `retire_cnt`=1 after 3 cycles; 10 instructions → `retire_cnt`=10 after 30 cycles.
- `sw` with `lsu_valid` delayed 5 cycles: `lsu_req` high for 6 cycles with `lsu_we`=1; in WB, `gpr_w_en`=0 even with `gpr_w_req`=1; `pc_w_en`=1.
- `ebreak` (type I): HALT entered after EXEC; `halt`=1 and `retire_cnt`+1; no write enable ever asserted; further `ifu_valid` has no effect; `rst` returns to FETCH with `retire_cnt`=0.
- `inst_type`=7 (invalid) in EXEC → ERROR next cycle, `error`=1. `TIMEOUT_CYCLES`=4 with `ifu_valid` low → ERROR after exactly 4 FETCH cycles; `ifu_valid` in the 4th cycle → EXEC instead.
- `rst` asserted in the 2nd MEM cycle of a load: the next cycle is FETCH with `lsu_req`=0; no `gpr_w_en` pulse; `retire_cnt`=0.
- `pc_w_req`=1 held constantly, with `ifu_valid` and `lsu_valid` randomized: `pc_w_en` is high only in WB; the count of `pc_w_en` pulses equals `retire_cnt` minus the number of `ebreak`s.
